// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry skid buffer of pending register-file writes,
// architectural carry/zero/parity flags, branch pulse and operand forwarding.
module alu_wb_stage #(
  parameter int unsigned DW = 8,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_rslt,
  input  logic          in_sc,
  input  logic          in_pari,
  input  logic          in_absj,
  input  logic [RW-1:0] in_dst,
  input  logic          in_wen,
  input  logic          in_flag_we,
  input  logic          in_is_branch,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  output logic          sc_i,
  output logic          zero_flag,
  output logic          pari_flag,
  output logic          branch_taken,
  input  logic [RW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data
);

  localparam int unsigned CW = 2;

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_head;
  logic          w_head_nxt;
  logic [RW-1:0] r_dst  [2];
  logic [DW-1:0] r_data [2];
  logic          r_sc;
  logic          r_zero;
  logic          r_pari;
  logic          r_branch;

  logic          w_accept;
  logic          w_enq;
  logic          w_retire;
  logic          w_tail;
  logic          w_newer;

  // Ready depends only on occupancy, never on the write port.
  assign in_ready = (r_count < CW'(2));
  assign w_accept = in_valid & in_ready;
  assign w_enq    = w_accept & in_wen;
  assign rf_we    = (r_count != CW'(0));
  assign w_retire = rf_we & rf_ready;
  // Enqueue only happens with count < 2, so tail = head + count (mod 2).
  assign w_tail   = r_head ^ r_count[0];
  assign w_newer  = ~r_head;

  assign rf_waddr = rf_we ? r_dst[r_head]  : '0;
  assign rf_wdata = rf_we ? r_data[r_head] : '0;

  assign sc_i         = r_sc;
  assign zero_flag    = r_zero;
  assign pari_flag    = r_pari;
  assign branch_taken = r_branch;

  // Occupancy and head pointer update.
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    if (w_enq && !w_retire) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_enq && w_retire) begin
      w_count_nxt = r_count - CW'(1);
    end
    if (w_retire) begin
      w_head_nxt = ~r_head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_head    <= 1'b0;
      r_dst[0]  <= '0;
      r_dst[1]  <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      if (w_enq) begin
        r_dst[w_tail]  <= in_dst;
        r_data[w_tail] <= in_rslt;
      end
    end
  end

  // Architectural flags and one-cycle branch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sc     <= 1'b0;
      r_zero   <= 1'b1;
      r_pari   <= 1'b0;
      r_branch <= 1'b0;
    end else begin
      r_branch <= w_accept & in_is_branch & in_absj;
      if (w_accept && in_flag_we) begin
        r_sc   <= in_sc;
        r_zero <= (in_rslt == '0);
        r_pari <= in_pari;
      end
    end
  end

  // Forwarding lookup: the newer entry (only valid at count 2) takes priority.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if ((r_count == CW'(2)) && (r_dst[w_newer] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_data[w_newer];
    end else if ((r_count != CW'(0)) && (r_dst[r_head] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = r_data[r_head];
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: queue scoreboard of expected
// register-file writes plus a small flag/forwarding model.
module tb_alu_wb_stage;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 3;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_rslt;
  logic          in_sc;
  logic          in_pari;
  logic          in_absj;
  logic [RW-1:0] in_dst;
  logic          in_wen;
  logic          in_flag_we;
  logic          in_is_branch;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_ready;
  logic          sc_i;
  logic          zero_flag;
  logic          pari_flag;
  logic          branch_taken;
  logic [RW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  wr_t  sb[$];
  logic m_sc, m_zero, m_pari, m_branch;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_wb_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rslt(in_rslt),
    .in_sc(in_sc), .in_pari(in_pari), .in_absj(in_absj), .in_dst(in_dst),
    .in_wen(in_wen), .in_flag_we(in_flag_we), .in_is_branch(in_is_branch),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .sc_i(sc_i), .zero_flag(zero_flag), .pari_flag(pari_flag),
    .branch_taken(branch_taken),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"},  32'(in_ready),     32'd1);
    check({pfx, "_rf_we"},     32'(rf_we),        32'd0);
    check({pfx, "_rf_waddr"},  32'(rf_waddr),     32'd0);
    check({pfx, "_rf_wdata"},  32'(rf_wdata),     32'd0);
    check({pfx, "_sc_i"},      32'(sc_i),         32'd0);
    check({pfx, "_zero"},      32'(zero_flag),    32'd1);
    check({pfx, "_pari"},      32'(pari_flag),    32'd0);
    check({pfx, "_branch"},    32'(branch_taken), 32'd0);
    check({pfx, "_fwd_hit"},   32'(fwd_hit),      32'd0);
    check({pfx, "_fwd_data"},  32'(fwd_data),     32'd0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_sc     = 1'b0;
    m_zero   = 1'b1;
    m_pari   = 1'b0;
    m_branch = 1'b0;
  endtask

  // One clock: compare all outputs mid-cycle, update the model, advance past the edge.
  task automatic step();
    logic          exp_ready;
    logic          acc;
    logic          hit;
    logic [DW-1:0] fd;
    wr_t           h;
    @(negedge clk);
    exp_ready = (sb.size() < 2);
    h = (sb.size() != 0) ? sb[0] : '0;
    check("in_ready",     32'(in_ready),     32'(exp_ready));
    check("rf_we",        32'(rf_we),        32'(sb.size() != 0));
    check("rf_waddr",     32'(rf_waddr),     32'(h.a));
    check("rf_wdata",     32'(rf_wdata),     32'(h.d));
    check("sc_i",         32'(sc_i),         32'(m_sc));
    check("zero_flag",    32'(zero_flag),    32'(m_zero));
    check("pari_flag",    32'(pari_flag),    32'(m_pari));
    check("branch_taken", 32'(branch_taken), 32'(m_branch));
    hit = 1'b0;
    fd  = '0;
    foreach (sb[i]) begin
      if (sb[i].a == fwd_addr) begin
        hit = 1'b1;
        fd  = sb[i].d;
      end
    end
    check("fwd_hit",  32'(fwd_hit),  32'(hit));
    check("fwd_data", 32'(fwd_data), 32'(fd));
    acc = in_valid && exp_ready;
    if (sb.size() != 0 && rf_ready) void'(sb.pop_front());
    if (acc && in_wen) sb.push_back({in_dst, in_rslt});
    m_branch = acc && in_is_branch && in_absj;
    if (acc && in_flag_we) begin
      m_sc   = in_sc;
      m_zero = (in_rslt == '0);
      m_pari = in_pari;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [DW-1:0] rslt, input logic sc, input logic pari,
                    input logic absj, input logic [RW-1:0] dst, input logic wen,
                    input logic fwe, input logic br);
    in_valid     = 1'b1;
    in_rslt      = rslt;
    in_sc        = sc;
    in_pari      = pari;
    in_absj      = absj;
    in_dst       = dst;
    in_wen       = wen;
    in_flag_we   = fwe;
    in_is_branch = br;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rslt = '0; in_sc = 1'b0; in_pari = 1'b0;
    in_absj = 1'b0; in_dst = '0; in_wen = 1'b0; in_flag_we = 1'b0;
    in_is_branch = 1'b0; rf_ready = 1'b1; fwd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // Single zero-result op with carry.
    op(8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0);
    check("t1_rf_we",    32'(rf_we),     32'd1);
    check("t1_rf_waddr", 32'(rf_waddr),  32'd3);
    check("t1_rf_wdata", 32'(rf_wdata),  32'h00);
    check("t1_sc_i",     32'(sc_i),      32'd1);
    check("t1_zero",     32'(zero_flag), 32'd1);
    idle(2);

    // Backpressure: third op refused while full.
    rf_ready = 1'b0;
    op(8'h11, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
    op(8'h22, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    check("t2_full_ready", 32'(in_ready), 32'd0);
    op(8'h77, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0);
    rf_ready = 1'b1;
    idle(1);
    check("t2_second_data", 32'(rf_wdata), 32'h22);
    check("t2_ready_back",  32'(in_ready), 32'd1);
    idle(2);

    // Forwarding: newest entry wins.
    rf_ready = 1'b0;
    op(8'hAA, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    op(8'hBB, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0);
    fwd_addr = 3'd5;
    #1;
    check("t3_hit5",  32'(fwd_hit),  32'd1);
    check("t3_data5", 32'(fwd_data), 32'hBB);
    fwd_addr = 3'd4;
    #1;
    check("t3_hit4",  32'(fwd_hit),  32'd0);
    check("t3_data4", 32'(fwd_data), 32'h00);
    idle(1);
    rf_ready = 1'b1;
    idle(3);

    // Branch pulse.
    op(8'h01, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    check("t4_taken",     32'(branch_taken), 32'd1);
    check("t4_no_write",  32'(rf_we),        32'd0);
    idle(1);
    check("t4_pulse_end", 32'(branch_taken), 32'd0);
    op(8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    check("t4_not_taken", 32'(branch_taken), 32'd0);
    idle(1);

    // Flag hold on non-flagging op.
    op(8'h05, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    op(8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("t5_sc_hold",   32'(sc_i),      32'd1);
    check("t5_zero_hold", 32'(zero_flag), 32'd0);
    check("t5_pari_hold", 32'(pari_flag), 32'd1);
    idle(1);

    // Asynchronous reset with a full buffer.
    rf_ready = 1'b0;
    op(8'h3C, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
    op(8'hC3, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("arst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rf_ready = 1'b1;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rf_ready = 1'($urandom_range(0, 1));
      fwd_addr = RW'($urandom_range(0, 7));
      op(DW'($urandom_range(0, 255)) & ((i % 7 == 0) ? 8'h00 : 8'hFF),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         RW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid) step();
      in_valid = 1'b0;
    end
    rf_ready = 1'b1;
    idle(3);
    check("final_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the 8-bit ALU. Captures each ALU result with its destination, holds up to two pending register-file writes in a skid buffer so a stalled write port does not stall the ALU, and keeps the architectural carry/zero/parity flags. The carry flag is fed back to the ALU as `sc_i`. The stage also offers a forwarding lookup to the operand-fetch stage.

## Interface
- `DW`, 8, data width (ALU result width)
- `RW`, 3, register address width

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  ALU result valid this cycle
- `in_ready`  out  1  stage can accept; `in_ready = (count < 2)`
- `in_rslt`  in  DW  ALU `rslt`
- `in_sc`  in  1  ALU `sc_o`
- `in_pari`  in  1  ALU `pari`
- `in_absj`  in  1  ALU `absj` (branch condition)
- `in_dst`  in  RW  destination register
- `in_wen`  in  1  result writes the register file
- `in_flag_we`  in  1  op updates carry/zero/parity flags
- `in_is_branch`  in  1  op is a conditional branch
- `rf_we`  out  1  register-file write request (head entry valid)
- `rf_waddr`  out  RW  head entry address; 0 when empty
- `rf_wdata`  out  DW  head entry data; 0 when empty
- `rf_ready`  in  1  register file accepts write this cycle
- `sc_i`  out  1  carry flag to ALU
- `zero_flag`  out  1  last flagged result == 0
- `pari_flag`  out  1  last flagged parity
- `branch_taken`  out  1  one-cycle pulse
- `fwd_addr`  in  RW  operand-fetch lookup address
- `fwd_hit`  out  1  pending write to `fwd_addr` exists
- `fwd_data`  out  DW  newest pending data for `fwd_addr`; 0 when no hit

## Operation
- Accept = `in_valid & in_ready`. Non-accepted inputs are ignored, with no side effects.
- Buffer: 2-entry FIFO of {dst, data}, with `count` in 0..2. Only accepted ops with `in_wen=1` enqueue. Ops with `in_wen=0` are accepted and update only flags and branch state.
- Retire = `rf_we & rf_ready`. The head pops.
- Same-cycle enqueue and retire: the count is unchanged and order is preserved (FIFO).
- `in_ready` depends only on `count`, never on `rf_ready`. At `count==2`, `in_ready=0` even if a retire occurs that cycle.
- Flags on accept with `in_flag_we=1`:
  - carry ← `in_sc`
  - zero ← (`in_rslt == 0`)
  - parity ← `in_pari`
  - With `in_flag_we=0`, flags hold.
- `sc_i` is the carry register. It is updated at the accept edge, so the next ALU op sees it.
- `branch_taken` is registered as `accept & in_is_branch & in_absj`. It is high for exactly one cycle after the accept edge.
- Forwarding: combinational compare of `fwd_addr` against valid entries. When both entries match, the newer entry wins. The op being accepted in the current cycle is not visible to the lookup. An entry retiring this cycle still counts as a hit.
- Data width: results are stored as full DW bits, with no truncation or extension.

## Timing
- Reset values: `count=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `sc_i=0`, `zero_flag=1`, `pari_flag=0`, `branch_taken=0`, `fwd_hit=0`, `fwd_data=0`, `in_ready=1`.
- Reset asserted mid-operation discards all pending writes immediately, without waiting for a clock edge.
- Latency: an op accepted at edge N drives `rf_we` from cycle N+1 when the buffer was empty. Otherwise it waits behind the head.
- Throughput: 1 op/cycle while `rf_ready=1`.
- A held `rf_ready=0` blocks the stage after two `in_wen` ops. Flag-only ops still need `in_ready`.
- `rf_waddr`/`rf_wdata` are stable while `rf_we=1` and `rf_ready=0`.
- FIFO pointers wrap modulo 2. The full/empty distinction comes from `count`, not from pointer equality.

## Test plan
- Reset, then one op {`in_rslt=0x00`, `in_sc=1`, `in_dst=3`, `in_wen=1`, `in_flag_we=1`} with `rf_ready=1` → next cycle `rf_we=1`, `rf_waddr=3`, `rf_wdata=0x00`, `sc_i=1`, `zero_flag=1`; `count` returns to 0 after the retire.
- `rf_ready=0`; send writes r1=0x11, r2=0x22, then a third valid op → `in_ready=0` after the second accept and the third op is not accepted. Raise `rf_ready` → writes 0x11 then 0x22 in order, and `in_ready` returns to 1.
- `rf_ready=0`; buffer r5=0xAA then r5=0xBB; `fwd_addr=5` → `fwd_hit=1`, `fwd_data=0xBB`. With `fwd_addr=4` → `fwd_hit=0`, `fwd_data=0`.
- Branch op `in_is_branch=1`, `in_absj=1`, `in_wen=0` → `branch_taken` high exactly one cycle, `count` unchanged. The same op with `in_absj=0` → no pulse.
- Flag hold: flagged op with `in_sc=1`, then an op with `in_flag_we=0` and `in_sc=0` → `sc_i` stays 1 and `zero_flag`/`pari_flag` are unchanged.
- With `count=2` and `rf_ready=0`, assert `reset` between edges → all outputs take their reset values immediately. After reset release, no stale write appears.
